alk_mdseq: RTL and testbench
============================

Name: alk_mdseq

Overview:
- Multiply/divide loop sequencer on the DPM ALK datapath.
- Produces the 10-bit ALPCTL micro-op stream and the loop flag for MUL, DIV, DIVD and REM iteration loops.
- This is the encoder side of the ALPCTL decode: each emitted code matches exactly one MUL/DIV/DIVD/REM/WB_LOOPF decode term.
- Sits between the microsequencer start request and the ALK control decode.

Parameters:
- CNT_W, 6, width of the iteration count and the internal down-counter.

Ports:
- clk_h  in  1  single clock; all state changes on its rising edge.
- reset_h  in  1  synchronous, active-high reset.
- start_h  in  1  begin an operation; sampled only in IDLE.
- op_h  in  2  00 MUL, 01 DIV, 10 DIVD, 11 REM; latched on start.
- slow_h  in  1  0 = FAST step codes, 1 = SLOW step codes; latched on start.
- count_h  in  CNT_W  number of loop steps; latched on start.
- sign_in_h  in  1  ALU result sign of the current step; selects N/P for the next step.
- stall_h  in  1  freeze the sequencer for this cycle.
- alpctl_h  out  10  registered ALPCTL code.
- loop_flag_h  out  1  registered loop flag.
- busy_h  out  1  high in any state other than IDLE.
- done_h  out  1  one-cycle completion pulse.

Behaviour:
- Reset and clocking:
  - Clock is clk_h; reset is synchronous, active-high, on reset_h.
  - Reset forces IDLE and all outputs to 0: alpctl_h=0x000, loop_flag_h=0, busy_h=0, done_h=0.
  - Reset asserted mid-operation aborts the operation; the next cycle is IDLE with all outputs 0.
- All outputs are registered and decoded from state, counter and latched fields. The first code appears the cycle after start_h is sampled.
- States: IDLE, LOOP, FIX, WB.
- IDLE:
  - alpctl_h=0x000.
  - On start_h: latch op, slow and count; clear the sign register (s=0, meaning P).
  - If count_h!=0, go to LOOP with cnt=count_h.
  - Otherwise skip LOOP: go to FIX for DIVD/REM, or to WB for MUL/DIV.
- LOOP: one step per non-stalled cycle.
  - MUL step code = 0x269 | s<<4 | slow<<1 (values 269/279/26B/27B).
  - DIV, DIVD and REM step code = 0x26C | s<<4 | slow<<1 (values 26C/27C/26E/27E).
  - loop_flag_h=1 when cnt>1; loop_flag_h=0 on the last step (cnt==1).
  - At the end of each non-stalled step: s <= sign_in_h and cnt <= cnt-1.
  - When cnt==1: go to FIX for DIVD/REM, or to WB for MUL/DIV.
- FIX: one cycle, loop_flag_h=0.
  - DIVD: alpctl_h = 0x26F | s<<4.
  - REM: alpctl_h = 0x26A.
  - Then go to WB.
- WB: one cycle.
  - alpctl_h=0x378 (WB_LOOPF), loop_flag_h=0, done_h=1.
  - Next state is IDLE. IDLE outputs alpctl_h=0x000; busy_h drops the cycle after WB.
- stall_h:
  - Holds state, cnt, s and every output unchanged; sign_in_h is not sampled.
  - A stalled WB cycle holds done_h high. done_h is counted as a single completion event, on the cycle where the WB code is present and stall_h=0.
- start_h while busy_h=1 is ignored (no re-latch).
- start_h in the same cycle that WB exits is also ignored; start is accepted only from IDLE.
- Step-count width: count_h up to 2^CNT_W-1; there is no wrap. cnt never decrements below 1 inside LOOP.
- op_h, slow_h and count_h changing during an operation have no effect.
- Total latency, not stalled: count + (1 if DIVD/REM) + 1 cycles from the first code to done_h.

Test Plan:
- MUL fast: start with count=3; sign_in_h=1 during step 1 and 0 during step 2. Required alpctl sequence: 269, 279, 269, 378. Required loop_flag sequence: 1, 1, 0, 0. done_h high on the 378 cycle only; busy_h high for 4 cycles.
- DIVD slow: start with count=2; sign_in_h=1 on both steps. Required alpctl sequence: 26E, 27E, 27F, 378.
- REM: start with count=0. Required alpctl sequence: 26A, 378. loop_flag_h=0 throughout.
- Stall: DIV fast, count=2; stall_h=1 for 2 cycles during step 1. 26C is held for 3 cycles, sign_in_h is ignored while stalled, then 26C/27C, 378. done_h counted once.
- Abort and reset: reset_h asserted during LOOP of MUL count=10. The next cycle shows alpctl_h=0x000, loop_flag_h=0, busy_h=0, done_h=0. A subsequent start runs from step 1 with s=0.
- Ignored start: assert start_h with op=DIV while a MUL is running. The MUL sequence is unchanged and no second operation begins after WB.

Source files
------------

// File: rtl/alk_mdseq.sv
// alk_mdseq: multiply/divide loop sequencer for the DPM ALK datapath.
// Emits the 10-bit ALPCTL micro-op stream and loop flag for MUL, DIV,
// DIVD and REM iteration loops. Every output is registered and decoded
// from the state being entered, so the first code appears the cycle
// after start_h is accepted.
module alk_mdseq #(
    parameter int CNT_W = 6
) (
    input  logic             clk_h,
    input  logic             reset_h,
    input  logic             start_h,
    input  logic [1:0]       op_h,
    input  logic             slow_h,
    input  logic [CNT_W-1:0] count_h,
    input  logic             sign_in_h,
    input  logic             stall_h,
    output logic [9:0]       alpctl_h,
    output logic             loop_flag_h,
    output logic             busy_h,
    output logic             done_h
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOP = 2'd1,
        ST_FIX  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [1:0]       OP_MUL   = 2'b00;
    localparam logic [1:0]       OP_DIVD  = 2'b10;
    localparam logic [1:0]       OP_REM   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Only the divide variants that leave a quotient/remainder to fix up
    // need the extra FIX cycle before write-back.
    function automatic logic needs_fix(input logic [1:0] op);
        return (op == OP_DIVD) || (op == OP_REM);
    endfunction

    // Loop step code: MUL uses the 0x269 family, all divides 0x26C;
    // bit 4 carries the previous step's sign (N), bit 1 selects SLOW.
    function automatic logic [9:0] step_code(input logic [1:0] op,
                                             input logic       s,
                                             input logic       slow);
        logic [9:0] base;
        base = (op == OP_MUL) ? 10'h269 : 10'h26C;
        return base | {5'b00000, s, 2'b00, slow, 1'b0};
    endfunction

    state_t           state_r,  state_nxt_s;
    logic [CNT_W-1:0] cnt_r,    cnt_nxt_s;
    logic             s_r,      s_nxt_s;
    logic [1:0]       op_r,     op_nxt_s;
    logic             slow_r,   slow_nxt_s;

    logic [9:0]       alpctl_r, alpctl_nxt_s;
    logic             loop_flag_r, loop_flag_nxt_s;
    logic             busy_r,   busy_nxt_s;
    logic             done_r,   done_nxt_s;

    // Next-state logic for the sequencer and its latched operation fields.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        s_nxt_s     = s_r;
        op_nxt_s    = op_r;
        slow_nxt_s  = slow_r;
        if (stall_h) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_h) begin
                        op_nxt_s   = op_h;
                        slow_nxt_s = slow_h;
                        s_nxt_s    = 1'b0;
                        cnt_nxt_s  = count_h;
                        if (count_h != CNT_ZERO) begin
                            state_nxt_s = ST_LOOP;
                        end else if (needs_fix(op_h)) begin
                            state_nxt_s = ST_FIX;
                        end else begin
                            state_nxt_s = ST_WB;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOOP: begin
                    s_nxt_s = sign_in_h;
                    if (cnt_r > CNT_ONE) begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                    end else if (needs_fix(op_r)) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_WB;
                    end
                end
                ST_FIX: begin
                    state_nxt_s = ST_WB;
                end
                ST_WB: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode of the state being entered, so outputs can be registered.
    always_comb begin
        alpctl_nxt_s    = 10'h000;
        loop_flag_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        done_nxt_s      = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                alpctl_nxt_s = 10'h000;
            end
            ST_LOOP: begin
                alpctl_nxt_s    = step_code(op_nxt_s, s_nxt_s, slow_nxt_s);
                loop_flag_nxt_s = (cnt_nxt_s > CNT_ONE);
                busy_nxt_s      = 1'b1;
            end
            ST_FIX: begin
                busy_nxt_s = 1'b1;
                if (op_nxt_s == OP_DIVD) begin
                    alpctl_nxt_s = 10'h26F | {5'b00000, s_nxt_s, 4'b0000};
                end else begin
                    alpctl_nxt_s = 10'h26A;
                end
            end
            ST_WB: begin
                alpctl_nxt_s = 10'h378;
                busy_nxt_s   = 1'b1;
                done_nxt_s   = 1'b1;
            end
            default: begin
                alpctl_nxt_s = 10'h000;
            end
        endcase
    end

    // Sequencer state and latched operation fields.
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            s_r     <= 1'b0;
            op_r    <= 2'b00;
            slow_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            s_r     <= s_nxt_s;
            op_r    <= op_nxt_s;
            slow_r  <= slow_nxt_s;
        end
    end

    // Output registers; a stall freezes them along with the state.
    always_ff @(posedge clk_h) begin
        if (reset_h) begin
            alpctl_r    <= 10'h000;
            loop_flag_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (stall_h) begin
            alpctl_r    <= alpctl_r;
            loop_flag_r <= loop_flag_r;
            busy_r      <= busy_r;
            done_r      <= done_r;
        end else begin
            alpctl_r    <= alpctl_nxt_s;
            loop_flag_r <= loop_flag_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
        end
    end

    assign alpctl_h    = alpctl_r;
    assign loop_flag_h = loop_flag_r;
    assign busy_h      = busy_r;
    assign done_h      = done_r;

endmodule

// File: tb/tb_alk_mdseq.sv
// Bench for alk_mdseq: directed operations, a sequence-list model that is
// compared every cycle, plus literal expectations for each scenario.
module tb_alk_mdseq;

    localparam int CNT_W = 6;

    logic             clk_h = 1'b0;
    logic             reset_h, start_h, slow_h, sign_in_h, stall_h;
    logic [1:0]       op_h;
    logic [CNT_W-1:0] count_h;
    logic [9:0]       alpctl_h;
    logic             loop_flag_h, busy_h, done_h;

    alk_mdseq #(.CNT_W(CNT_W)) dut (
        .clk_h       (clk_h),
        .reset_h     (reset_h),
        .start_h     (start_h),
        .op_h        (op_h),
        .slow_h      (slow_h),
        .count_h     (count_h),
        .sign_in_h   (sign_in_h),
        .stall_h     (stall_h),
        .alpctl_h    (alpctl_h),
        .loop_flag_h (loop_flag_h),
        .busy_h      (busy_h),
        .done_h      (done_h)
    );

    always #5 clk_h = ~clk_h;

    typedef struct packed {
        logic [9:0] code;
        logic       flag;
        logic       busy;
        logic       done;
    } ent_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_events = 0;
    bit          chk_en = 1'b0;
    logic [63:0] sign_plan = 64'h0;
    logic [9:0]  obs_code[$];
    logic        obs_flag[$];
    ent_t        mq[$];
    ent_t        exp_e = '0;
    int          m_n;
    logic        m_sg;
    logic [9:0]  m_base;

    function automatic ent_t mk(input logic [9:0] code, input logic flag,
                                input logic done);
        ent_t e;
        e.code = code;
        e.flag = flag;
        e.busy = 1'b1;
        e.done = done;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: on an accepted start the whole expected sequence is built as a
    // list from op/slow/count and the planned per-step signs; each
    // non-stalled edge moves to the next entry, otherwise the idle entry.
    always @(posedge clk_h) begin
        if (reset_h) begin
            mq.delete();
            exp_e = '0;
        end else if (stall_h) begin
            exp_e = exp_e;
        end else if (mq.size() > 0) begin
            exp_e = mq.pop_front();
        end else if (start_h && !exp_e.busy) begin
            m_n    = int'(count_h);
            m_base = (op_h == 2'b00) ? 10'h269 : 10'h26C;
            for (int i = 0; i < m_n; i++) begin
                m_sg = (i == 0) ? 1'b0 : sign_plan[i-1];
                mq.push_back(mk(m_base + (m_sg ? 10'd16 : 10'd0) + (slow_h ? 10'd2 : 10'd0),
                                (i < m_n - 1), 1'b0));
            end
            m_sg = (m_n == 0) ? 1'b0 : sign_plan[m_n-1];
            if (op_h == 2'b10) mq.push_back(mk(m_sg ? 10'h27F : 10'h26F, 1'b0, 1'b0));
            if (op_h == 2'b11) mq.push_back(mk(10'h26A, 1'b0, 1'b0));
            mq.push_back(mk(10'h378, 1'b0, 1'b1));
            exp_e = mq.pop_front();
        end else begin
            exp_e = '0;
        end
    end

    // Compare every cycle on the falling edge and record the busy stream.
    always @(negedge clk_h) begin
        if (chk_en) begin
            chk("alpctl", {22'd0, alpctl_h}, {22'd0, exp_e.code});
            chk("loop_flag", {31'd0, loop_flag_h}, {31'd0, exp_e.flag});
            chk("busy", {31'd0, busy_h}, {31'd0, exp_e.busy});
            chk("done", {31'd0, done_h}, {31'd0, exp_e.done});
            if (busy_h) begin
                obs_code.push_back(alpctl_h);
                obs_flag.push_back(loop_flag_h);
            end
            if (done_h && !stall_h) done_events++;
        end
    end

    task automatic cyc(input logic st, input logic stl, input logic sg);
        start_h   = st;
        stall_h   = stl;
        sign_in_h = sg;
        @(posedge clk_h);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, sign_plan[i]);
    endtask

    task automatic start_op(input logic [1:0] op, input logic slow,
                            input logic [CNT_W-1:0] cnt);
        op_h    = op;
        slow_h  = slow;
        count_h = cnt;
        obs_code.delete();
        obs_flag.delete();
        cyc(1'b1, 1'b0, 1'b0);
        start_h = 1'b0;
    endtask

    // want holds len codes, first code in the most significant used slot.
    task automatic chk_seq(input string name, input int len, input logic [99:0] want);
        chk({name, " len"}, obs_code.size(), len);
        for (int i = 0; i < len && i < obs_code.size(); i++)
            chk(name, {22'd0, obs_code[i]}, {22'd0, want[(len-1-i)*10 +: 10]});
    endtask

    task automatic chk_flags(input string name, input int len, input logic [15:0] want);
        for (int i = 0; i < len && i < obs_flag.size(); i++)
            chk(name, {31'd0, obs_flag[i]}, {31'd0, want[len-1-i]});
    endtask

    int d0;

    initial begin
        reset_h = 1'b1; start_h = 1'b0; stall_h = 1'b0; sign_in_h = 1'b0;
        op_h = 2'b00; slow_h = 1'b0; count_h = '0;
        @(posedge clk_h); #1;
        @(posedge clk_h); #1;
        chk("reset alpctl", {22'd0, alpctl_h}, 32'h0);
        chk("reset busy", {31'd0, busy_h}, 32'h0);
        chk("reset done", {31'd0, done_h}, 32'h0);
        chk_en  = 1'b1;
        reset_h = 1'b0;
        idle(2);

        // MUL fast, count 3, sign 1 then 0
        sign_plan = 64'h1;
        d0 = done_events;
        start_op(2'b00, 1'b0, 6'd3);
        run(4); idle(2);
        chk_seq("mul seq", 4, {10'h269, 10'h279, 10'h269, 10'h378});
        chk_flags("mul flag", 4, 16'b1100);
        chk("mul done count", done_events - d0, 1);

        // DIVD slow, count 2, signs 1,1
        sign_plan = 64'h3;
        start_op(2'b10, 1'b1, 6'd2);
        run(4); idle(1);
        chk_seq("divd seq", 4, {10'h26E, 10'h27E, 10'h27F, 10'h378});

        // REM, count 0
        sign_plan = 64'h0;
        start_op(2'b11, 1'b0, 6'd0);
        run(2); idle(1);
        chk_seq("rem seq", 2, {10'h26A, 10'h378});
        chk_flags("rem flag", 2, 16'b00);

        // DIV, count 0 goes straight to write-back
        start_op(2'b01, 1'b0, 6'd0);
        run(1); idle(2);
        chk_seq("div0 seq", 1, {10'h378});

        // DIV fast with 2-cycle stall in step 1 and a stalled WB
        sign_plan = 64'h1;
        d0 = done_events;
        start_op(2'b01, 1'b0, 6'd2);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        idle(2);
        chk_seq("stall seq", 6, {10'h26C, 10'h26C, 10'h26C, 10'h27C, 10'h378, 10'h378});
        chk("stall done count", done_events - d0, 1);

        // Abort MUL count 10 with reset, then restart
        sign_plan = {64{1'b1}};
        start_op(2'b00, 1'b0, 6'd10);
        run(3);
        reset_h = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        reset_h = 1'b0;
        chk("abort alpctl", {22'd0, alpctl_h}, 32'h0);
        chk("abort flag", {31'd0, loop_flag_h}, 32'h0);
        chk("abort busy", {31'd0, busy_h}, 32'h0);
        chk("abort done", {31'd0, done_h}, 32'h0);
        sign_plan = 64'h0;
        start_op(2'b00, 1'b0, 6'd2);
        chk("restart first", {22'd0, alpctl_h}, 32'h269);
        run(3); idle(1);
        chk_seq("restart seq", 3, {10'h269, 10'h269, 10'h378});

        // Start requests while busy and on WB exit are ignored
        sign_plan = 64'h2;
        start_op(2'b00, 1'b1, 6'd3);
        op_h = 2'b01; count_h = 6'd5;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("ignored busy", {31'd0, busy_h}, 32'h0);
        idle(2);
        chk_seq("ignored seq", 4, {10'h26B, 10'h26B, 10'h27B, 10'h378});

        // Maximum count, DIV slow, alternating signs
        sign_plan = 64'h5555_5555_5555_5555;
        start_op(2'b01, 1'b1, 6'd63);
        run(65); idle(1);
        chk("max len", obs_code.size(), 64);
        if (obs_code.size() == 64) begin
            chk("max step2", {22'd0, obs_code[1]}, 32'h27E);
            chk("max last step", {22'd0, obs_code[62]}, 32'h26E);
            chk("max wb", {22'd0, obs_code[63]}, 32'h378);
            chk("max flag 61", {31'd0, obs_flag[61]}, 32'h1);
            chk("max flag 62", {31'd0, obs_flag[62]}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
